// File: rtl/wide_capture_ram_wb_if.sv
// Wishbone slave bundle for the wide capture buffer.
// AW must match the AW localparam of the wide_capture_ram_wb instance it is attached to.
interface wide_capture_ram_wb_if #(parameter int AW = 8);
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [AW+1:2] wb_adr_i;
  logic [3:0]    wb_sel_i;
  logic          wb_we_i;
  logic [31:0]   wb_dat_i;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          wb_rty_o;
  logic          wb_stall_o;
  logic [31:0]   wb_dat_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i,
    output wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o, wb_dat_o
  );
  modport master (
    output wb_cyc_i, wb_stb_i, wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i,
    input  wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o, wb_dat_o
  );
endinterface

// File: rtl/wide_capture_ram_wb.sv
// Bus-read-only wide capture buffer: a stream fills G_LANES*32-bit entries under a small FSM,
// and the CPU reads them lane by lane over Wishbone with coherent multi-lane snapshots.
module wide_capture_ram_wb #(
  parameter int G_LANES      = 2,
  parameter int G_DEPTH_LOG2 = 6,
  parameter int G_WRAP       = 1,
  localparam int LB = (G_LANES > 1) ? $clog2(G_LANES) : 0,
  localparam int AW = G_DEPTH_LOG2 + LB + 1,
  localparam int SW = 32 * G_LANES
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  wide_capture_ram_wb_if.slave wb,
  input  logic                cap_valid_i,
  input  logic [SW-1:0]       cap_dat_i,
  output logic                cap_run_o,
  output logic                cap_done_o
);
  localparam int DEPTH = 2 ** G_DEPTH_LOG2;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
  localparam logic [AW-2:0] LMASK = (AW-1)'((1 << LB) - 1);

  logic [1:0]              state;
  logic [G_DEPTH_LOG2-1:0] wptr;
  logic                    full, wrapped;
  logic [SW-1:0]           ram [DEPTH];
  logic [SW-1:0]           ram_q, shadow;

  // second-stage request: memory reads and all writes complete one cycle later
  logic          p_vld, p_we, p_mem;
  logic [AW-2:0] p_word;
  logic [2:0]    p_ctl;

  logic                    top, req;
  logic [AW-2:0]           word, p_lane;
  logic [G_DEPTH_LOG2-1:0] ent;
  logic [31:0]             reg_rd;
  logic                    ctrl_wr, arm, stop, clr, cap_we;
  logic                    unused_ok;

  assign top    = wb.wb_adr_i[AW+1];
  assign word   = wb.wb_adr_i[AW:2];
  assign ent    = G_DEPTH_LOG2'(word >> LB);
  assign p_lane = p_word & LMASK;
  assign req    = wb.wb_cyc_i & wb.wb_stb_i & ~p_vld & ~wb.wb_ack_o;

  assign ctrl_wr = p_vld & p_we & ~p_mem & (p_word == '0);
  assign clr     = ctrl_wr & p_ctl[2];
  assign arm     = ctrl_wr & p_ctl[0];
  assign stop    = ctrl_wr & p_ctl[1];
  assign cap_we  = (state == S_RUN) & cap_valid_i & ~clr & ~arm;

  assign cap_run_o     = (state == S_RUN);
  assign cap_done_o    = (state == S_DONE);
  assign wb.wb_err_o   = 1'b0;
  assign wb.wb_rty_o   = 1'b0;
  assign wb.wb_stall_o = ~wb.wb_ack_o & wb.wb_cyc_i & wb.wb_stb_i;
  assign unused_ok     = ^{wb.wb_dat_i[31:3], wb.wb_sel_i[3:1]};

  function automatic logic [31:0] lane_of(logic [SW-1:0] v, logic [AW-2:0] l);
    lane_of = '0;
    for (int k = 0; k < G_LANES; k++)
      if (l == (AW-1)'(k)) lane_of = v[SW-1-32*k -: 32];
  endfunction

  always_comb begin
    reg_rd = '0;
    if (word == (AW-1)'(1)) reg_rd = {28'd0, wrapped, full, cap_done_o, cap_run_o};
    else if (word == (AW-1)'(2)) reg_rd = {{(32-G_DEPTH_LOG2){1'b0}}, wptr};
  end

  // capture write and bus read share the array; nonblocking update makes reads see old data
  always_ff @(posedge clk_i) begin
    if (cap_we) ram[wptr] <= cap_dat_i;
    if (req && top && !wb.wb_we_i) ram_q <= ram[ent];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
      p_vld <= 1'b0; p_we <= 1'b0; p_mem <= 1'b0; p_word <= '0; p_ctl <= '0;
      shadow <= '0;
    end else begin
      wb.wb_ack_o <= 1'b0;
      if (req) begin
        if (!top && !wb.wb_we_i) begin
          wb.wb_ack_o <= 1'b1;
          wb.wb_dat_o <= reg_rd;
        end else begin
          p_vld  <= 1'b1;
          p_we   <= wb.wb_we_i;
          p_mem  <= top;
          p_word <= word;
          p_ctl  <= wb.wb_dat_i[2:0] & {3{wb.wb_sel_i[0]}};
        end
      end
      if (p_vld) begin
        p_vld       <= 1'b0;
        wb.wb_ack_o <= 1'b1;
        if (p_mem && !p_we) begin
          if (p_lane == '0) begin
            wb.wb_dat_o <= lane_of(ram_q, '0);
            shadow      <= ram_q;
          end else begin
            wb.wb_dat_o <= lane_of(shadow, p_lane);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_IDLE; wptr <= '0; full <= 1'b0; wrapped <= 1'b0;
    end else if (clr) begin
      state <= S_IDLE; wptr <= '0; full <= 1'b0; wrapped <= 1'b0;
    end else if (arm) begin
      state <= S_RUN; wptr <= '0; full <= 1'b0; wrapped <= 1'b0;
    end else begin
      if (cap_we) begin
        wptr <= wptr + 1'b1;
        if (&wptr) begin
          if (G_WRAP != 0) wrapped <= 1'b1;
          else begin
            full  <= 1'b1;
            state <= S_DONE;
          end
        end
      end
      if (stop && state == S_RUN) state <= S_DONE;
    end
  end
endmodule

// File: tb/tb_wide_capture_ram_wb.sv
// Three instances (one-shot, ring, 4-lane ring) driven by directed steps with random samples,
// checked against a behavioural model of buffer contents, pointer, flags and shadow.
module tb_wide_capture_ram_wb;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic cv0 = 0, cv1 = 0, cv2 = 0;
  logic [63:0]  cd0 = '0, cd1 = '0;
  logic [127:0] cd2 = '0;
  logic run0, run1, run2, done0, done1, done2;

  wide_capture_ram_wb_if #(.AW(8)) i0 ();
  wide_capture_ram_wb_if #(.AW(8)) i1 ();
  wide_capture_ram_wb_if #(.AW(9)) i2 ();

  wide_capture_ram_wb #(.G_LANES(2), .G_DEPTH_LOG2(6), .G_WRAP(0)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .wb(i0.slave), .cap_valid_i(cv0), .cap_dat_i(cd0),
    .cap_run_o(run0), .cap_done_o(done0));
  wide_capture_ram_wb #(.G_LANES(2), .G_DEPTH_LOG2(6), .G_WRAP(1)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .wb(i1.slave), .cap_valid_i(cv1), .cap_dat_i(cd1),
    .cap_run_o(run1), .cap_done_o(done1));
  wide_capture_ram_wb #(.G_LANES(4), .G_DEPTH_LOG2(6), .G_WRAP(1)) u2 (
    .clk_i(clk), .rst_n_i(rst_n), .wb(i2.slave), .cap_valid_i(cv2), .cap_dat_i(cd2),
    .cap_run_o(run2), .cap_done_o(done2));

  int checks = 0, errors = 0;

  // model: per instance buffer, pointer, flags, and last lane-0 snapshot
  logic [127:0] m_mem [3][64];
  logic [127:0] m_shadow [3];
  int m_wptr [3];
  bit m_run [3], m_done [3], m_full [3], m_wrap [3];

  function automatic int nl(int d); return (d == 2) ? 4 : 2; endfunction

  function automatic logic [31:0] lane(int d, logic [127:0] v, int k);
    return v[32*(nl(d)-k)-1 -: 32];
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int d = 0; d < 3; d++) begin
      m_wptr[d] = 0; m_run[d] = 0; m_done[d] = 0; m_full[d] = 0; m_wrap[d] = 0;
      m_shadow[d] = '0;
    end
  endtask

  task automatic m_store(int d, logic [127:0] v);
    if (!m_run[d]) return;
    m_mem[d][m_wptr[d]] = v;
    m_wptr[d]++;
    if (m_wptr[d] == 64) begin
      m_wptr[d] = 0;
      if (d != 0) m_wrap[d] = 1;
      else begin m_full[d] = 1; m_run[d] = 0; m_done[d] = 1; end
    end
  endtask

  task automatic m_ctrl(int d, logic [2:0] b);
    if (b[2]) begin
      m_run[d] = 0; m_done[d] = 0; m_wptr[d] = 0; m_full[d] = 0; m_wrap[d] = 0;
    end else if (b[0]) begin
      m_run[d] = 1; m_done[d] = 0; m_wptr[d] = 0; m_full[d] = 0; m_wrap[d] = 0;
    end else if (b[1] && m_run[d]) begin
      m_run[d] = 0; m_done[d] = 1;
    end
  endtask

  task automatic drive(int d, bit cyc, bit we, bit mem, int word, logic [31:0] wd);
    case (d)
      0: begin i0.wb_cyc_i = cyc; i0.wb_stb_i = cyc; i0.wb_we_i = we; i0.wb_sel_i = 4'hf;
               i0.wb_adr_i = {mem, 7'(word)}; i0.wb_dat_i = wd; end
      1: begin i1.wb_cyc_i = cyc; i1.wb_stb_i = cyc; i1.wb_we_i = we; i1.wb_sel_i = 4'hf;
               i1.wb_adr_i = {mem, 7'(word)}; i1.wb_dat_i = wd; end
      default: begin i2.wb_cyc_i = cyc; i2.wb_stb_i = cyc; i2.wb_we_i = we; i2.wb_sel_i = 4'hf;
               i2.wb_adr_i = {mem, 8'(word)}; i2.wb_dat_i = wd; end
    endcase
  endtask

  function automatic logic ack_of(int d);
    return (d == 0) ? i0.wb_ack_o : (d == 1) ? i1.wb_ack_o : i2.wb_ack_o;
  endfunction
  function automatic logic [31:0] dat_of(int d);
    return (d == 0) ? i0.wb_dat_o : (d == 1) ? i1.wb_dat_o : i2.wb_dat_o;
  endfunction

  task automatic setcap(int d, bit v, logic [127:0] x);
    case (d)
      0: begin cv0 = v; cd0 = x[63:0]; end
      1: begin cv1 = v; cd1 = x[63:0]; end
      default: begin cv2 = v; cd2 = x; end
    endcase
  endtask

  task automatic bus(int d, bit we, bit mem, int word, logic [31:0] wd,
                     output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    drive(d, 1, we, mem, word, wd);
    lat = 0; rd = 'x;
    while (1) begin
      @(posedge clk); #1; lat++;
      if (ack_of(d)) begin rd = dat_of(d); break; end
      if (lat >= 8) begin chk("bus_ack_timeout", ack_of(d), 1); break; end
    end
    drive(d, 0, 0, 0, 0, 0);
  endtask

  task automatic rd_reg(int d, int idx, output logic [31:0] v);
    int lat;
    bus(d, 0, 0, idx, 0, v, lat);
    chk("reg_rd_latency", lat, 1);
  endtask

  task automatic wr_ctrl(int d, logic [2:0] b);
    logic [31:0] v; int lat;
    bus(d, 1, 0, 0, {29'd0, b}, v, lat);
    chk("wr_latency", lat, 2);
    m_ctrl(d, b);
  endtask

  task automatic chk_mem(int d, int e, int l);
    logic [31:0] v; int lat;
    bus(d, 0, 1, e*nl(d) + l, 0, v, lat);
    chk("mem_rd_latency", lat, 2);
    if (l == 0) m_shadow[d] = m_mem[d][e];
    chk($sformatf("mem d%0d e%0d l%0d", d, e, l), v, lane(d, m_shadow[d], l));
  endtask

  task automatic chk_status(int d);
    logic [31:0] v;
    rd_reg(d, 1, v);
    chk($sformatf("status d%0d", d), v, {28'd0, m_wrap[d], m_full[d], m_done[d], m_run[d]});
    rd_reg(d, 2, v);
    chk($sformatf("wptr d%0d", d), v, m_wptr[d]);
  endtask

  // pat=1 gives {k,~k}; otherwise random lanes
  task automatic cap(int d, int n, bit pat);
    logic [127:0] x;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      if (pat) x = {64'd0, 32'(i), ~32'(i)};
      if (d < 2) x[127:64] = '0;
      setcap(d, 1, x);
      @(posedge clk);
      m_store(d, x);
      #1;
    end
    setcap(d, 0, '0);
  endtask

  initial begin
    logic [31:0] v;
    logic [127:0] x;
    int lat;
    m_reset();
    for (int d = 0; d < 3; d++) drive(d, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1;

    chk("reset run0", run0, 0);
    chk("reset done0", done0, 0);
    chk("err tied", i0.wb_err_o, 0);
    chk_status(0);
    chk_status(2);

    // one-shot fill
    wr_ctrl(0, 3'b001);
    chk("armed run0", run0, 1);
    cap(0, 64, 1);
    chk("oneshot done0", done0, 1);
    chk_status(0);
    chk_mem(0, 5, 0);
    chk_mem(0, 5, 1);
    cap(0, 3, 1);
    chk_status(0);
    chk_mem(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      int e = $urandom_range(0, 63);
      chk_mem(0, e, 0);
      chk_mem(0, e, 1);
    end

    // ring wrap
    wr_ctrl(1, 3'b001);
    cap(1, 70, 0);
    chk_status(1);
    chk_mem(1, 0, 0);
    chk_mem(1, 0, 1);

    // shadow holds old lane 1 across an overwrite
    chk_mem(1, 3, 0);
    wr_ctrl(1, 3'b001);
    cap(1, 4, 0);
    chk_mem(1, 3, 1);
    chk_mem(1, 3, 0);
    chk_mem(1, 3, 1);

    // STOP lands in the same cycle as a sample at wptr=10
    wr_ctrl(1, 3'b001);
    cap(1, 10, 0);
    @(posedge clk); #1;
    drive(1, 1, 1, 0, 0, 32'h2);
    @(posedge clk); #1;
    x = {64'd0, $urandom, $urandom};
    setcap(1, 1, x);
    @(posedge clk); #1;
    chk("stop ack", i1.wb_ack_o, 1);
    m_store(1, x);
    m_ctrl(1, 3'b010);
    drive(1, 0, 0, 0, 0, 0);
    setcap(1, 0, '0);
    chk_status(1);
    chk_mem(1, 10, 0);
    chk_mem(1, 10, 1);
    cap(1, 2, 0);
    chk_status(1);

    // same-write priority
    wr_ctrl(1, 3'b101);
    chk_status(1);
    wr_ctrl(1, 3'b011);
    chk_status(1);
    wr_ctrl(1, 3'b110);
    chk_status(1);

    // four lanes: latencies, dropped memory write, unmapped registers
    wr_ctrl(2, 3'b001);
    cap(2, 5, 0);
    wr_ctrl(2, 3'b010);
    chk_status(2);
    for (int l = 0; l < 4; l++) chk_mem(2, 2, l);
    bus(2, 1, 1, 2*4, 32'hdead_beef, v, lat);
    chk("mem_wr_latency", lat, 2);
    chk_mem(2, 2, 0);
    rd_reg(2, 5, v);
    chk("unmapped reg", v, 0);
    rd_reg(2, 0, v);
    chk("ctrl reads 0", v, 0);

    // asynchronous reset in the middle of a run
    wr_ctrl(1, 3'b001);
    cap(1, 5, 0);
    chk("run before reset", run1, 1);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("async reset run1", run1, 0);
    m_reset();
    @(posedge clk); #1;
    rst_n = 1;
    chk_status(1);
    chk_mem(1, 2, 1);
    chk_mem(1, 2, 0);
    chk_mem(1, 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
